// File: rtl/ra_sample_arbiter_if.sv
// rtl/ra_sample_arbiter_if.sv - two-requester sample request/ack handshake bundle
interface ra_sample_arbiter_if #(
    parameter int BITS_PER_ELEM = 5
);
    logic                     req0;
    logic [BITS_PER_ELEM-1:0] val0;
    logic                     ack0;
    logic                     req1;
    logic [BITS_PER_ELEM-1:0] val1;
    logic                     ack1;

    modport master (
        output req0, val0, req1, val1,
        input  ack0, ack1
    );

    modport slave (
        input  req0, val0, req1, val1,
        output ack0, ack1
    );
endinterface

// File: rtl/ra_sample_arbiter.sv
// rtl/ra_sample_arbiter.sv - two-way sample arbiter feeding a rolling-average core (RA_ARB_RR_EN selects round-robin)
module ra_sample_arbiter #(
    parameter int RA_SIZE       = 8,
    parameter int BITS_PER_ELEM = 5,
    parameter int STROBE_CYCLES = 1,
    parameter int GAP_CYCLES    = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    ra_sample_arbiter_if.slave               arb,
    input  logic                             flush,
    output logic                             o_data_clk,
    output logic [BITS_PER_ELEM-1:0]         o_value,
    output logic                             o_src,
    output logic [$clog2(RA_SIZE+1)-1:0]     o_fill,
    output logic                             o_window_full
);
    localparam int CNT_MAX = (STROBE_CYCLES > GAP_CYCLES) ? STROBE_CYCLES : GAP_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int FW      = $clog2(RA_SIZE + 1);
    localparam logic [FW-1:0] FILL_MAX    = FW'(RA_SIZE);
    localparam logic [CW-1:0] STROBE_LAST = CW'(STROBE_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST    = CW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, STROBE, GAP} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          strobe_void;
    logic          any_req;
    logic          grant_sel;
    logic          fill_inc;
    logic [FW-1:0] fill_next;

    assign any_req = arb.req0 | arb.req1;

`ifdef RA_ARB_RR_EN
    logic last_grant;

    always_comb begin
        grant_sel = ~arb.req0;
        if (arb.req0 && arb.req1)
            grant_sel = ~last_grant;
    end

    always_ff @(posedge clk) begin
        if (rst)
            last_grant <= 1'b1;
        else if (state == IDLE && any_req)
            last_grant <= grant_sel;
    end
`else
    assign grant_sel = ~arb.req0;
`endif

    // A flush seen anywhere in the strobe voids the count for that sample.
    assign fill_inc = (state == STROBE) && (cnt == STROBE_LAST) && !strobe_void;

    always_comb begin
        fill_next = o_fill;
        if (flush)
            fill_next = '0;
        else if (fill_inc && o_fill != FILL_MAX)
            fill_next = o_fill + FW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            strobe_void   <= 1'b0;
            o_data_clk    <= 1'b0;
            arb.ack0      <= 1'b0;
            arb.ack1      <= 1'b0;
            o_value       <= '0;
            o_src         <= 1'b0;
            o_fill        <= '0;
            o_window_full <= 1'b0;
        end else begin
            arb.ack0      <= 1'b0;
            arb.ack1      <= 1'b0;
            o_fill        <= fill_next;
            o_window_full <= (fill_next == FILL_MAX);
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state       <= STROBE;
                        cnt         <= '0;
                        strobe_void <= 1'b0;
                        o_data_clk  <= 1'b1;
                        o_value     <= grant_sel ? arb.val1 : arb.val0;
                        o_src       <= grant_sel;
                        arb.ack0    <= ~grant_sel;
                        arb.ack1    <= grant_sel;
                    end
                end
                STROBE: begin
                    if (flush)
                        strobe_void <= 1'b1;
                    if (cnt == STROBE_LAST) begin
                        state      <= GAP;
                        cnt        <= '0;
                        o_data_clk <= 1'b0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                GAP: begin
                    if (cnt == GAP_LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ra_sample_arbiter.sv
// tb/tb_ra_sample_arbiter.sv - self-checking bench for ra_sample_arbiter
module tb_ra_sample_arbiter;
    localparam int RA = 8;
    localparam int B  = 5;
    localparam int S  = 1;
    localparam int G  = 2;
`ifdef RA_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic flush;
    logic o_data_clk;
    logic [B-1:0] o_value;
    logic o_src;
    logic [3:0] o_fill;
    logic o_window_full;
    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    ra_sample_arbiter_if #(.BITS_PER_ELEM(B)) bus ();

    ra_sample_arbiter #(
        .RA_SIZE(RA), .BITS_PER_ELEM(B), .STROBE_CYCLES(S), .GAP_CYCLES(G)
    ) dut (
        .clk(clk), .rst(rst), .arb(bus), .flush(flush),
        .o_data_clk(o_data_clk), .o_value(o_value), .o_src(o_src),
        .o_fill(o_fill), .o_window_full(o_window_full)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.req0 = 1'b0; bus.req1 = 1'b0; bus.val0 = '0; bus.val1 = '0; flush = 1'b0;
    endtask

    task automatic test_reset;
        idle_inputs();
        rst = 1'b1;
        bus.req0 = 1'b1; bus.val0 = 5'd9;
        step(); step();
        total_cnt++;
        if ({bus.ack0, bus.ack1, o_data_clk, o_src, o_value, o_fill, o_window_full} !== 14'd0)
            $display("FAIL reset_state: got %h exp 0",
                     {bus.ack0, bus.ack1, o_data_clk, o_src, o_value, o_fill, o_window_full});
        else pass_cnt++;
        bus.req0 = 1'b0;
        rst = 1'b0;
        step();
        total_cnt++;
        if ({bus.ack0, bus.ack1, o_data_clk} !== 3'b000)
            $display("FAIL reset_release_ack: got %b exp 000", {bus.ack0, bus.ack1, o_data_clk});
        else pass_cnt++;
    endtask

    task automatic test_single;
        bus.req0 = 1'b1; bus.val0 = 5'd17;
        step();
        total_cnt++;
        if ({bus.ack0, bus.ack1, o_data_clk, o_src, o_value} !== {4'b1010, 5'd17})
            $display("FAIL single_grant: got %h exp %h",
                     {bus.ack0, bus.ack1, o_data_clk, o_src, o_value}, {4'b1010, 5'd17});
        else pass_cnt++;
        bus.req0 = 1'b0;
        step();
        total_cnt++;
        if ({bus.ack0, o_data_clk, o_fill} !== {2'b00, 4'd1})
            $display("FAIL single_gap1: got %h exp %h", {bus.ack0, o_data_clk, o_fill}, {2'b00, 4'd1});
        else pass_cnt++;
        bus.req1 = 1'b1; bus.val1 = 5'd3;
        step();
        total_cnt++;
        if ({o_data_clk, o_value} !== {1'b0, 5'd17})
            $display("FAIL single_gap2: got %h exp %h", {o_data_clk, o_value}, {1'b0, 5'd17});
        else pass_cnt++;
        step();
        total_cnt++;
        if ({bus.ack1, o_data_clk} !== 2'b00)
            $display("FAIL single_idle_no_grant: got %b exp 00", {bus.ack1, o_data_clk});
        else pass_cnt++;
        step();
        total_cnt++;
        if ({bus.ack0, bus.ack1, o_data_clk, o_src, o_value} !== {4'b0111, 5'd3})
            $display("FAIL single_next_grant: got %h exp %h",
                     {bus.ack0, bus.ack1, o_data_clk, o_src, o_value}, {4'b0111, 5'd3});
        else pass_cnt++;
        bus.req1 = 1'b0;
        step(); step(); step();
    endtask

    task automatic test_contention;
        int k = 0;
        bus.req0 = 1'b1; bus.req1 = 1'b1; bus.val0 = 5'd1; bus.val1 = 5'd2;
        for (int s = 1; s <= 16; s++) begin
            step();
            if (bus.ack0 || bus.ack1) begin
                logic exp_src;
                exp_src = RR ? k[0] : 1'b0;
                total_cnt++;
                if ({bus.ack1, o_src} !== {exp_src, exp_src} || s != 1 + 4 * k)
                    $display("FAIL contention_grant%0d: got src %0d at step %0d exp src %0d at step %0d",
                             k, o_src, s, exp_src, 1 + 4 * k);
                else pass_cnt++;
                k++;
                if (k == 4) begin bus.req0 = 1'b0; bus.req1 = 1'b0; end
            end
        end
        total_cnt++;
        if (k != 4) $display("FAIL contention_count: got %0d exp 4", k);
        else pass_cnt++;
    endtask

    task automatic test_fill;
        int acks = 0;
        int ef;
        flush = 1'b1;
        step();
        flush = 1'b0;
        total_cnt++;
        if ({o_fill, o_window_full} !== 5'd0)
            $display("FAIL fill_flushed: got %h exp 0", {o_fill, o_window_full});
        else pass_cnt++;
        bus.req0 = 1'b1; bus.val0 = 5'($urandom);
        for (int c = 1; c <= 36; c++) begin
            step();
            if (bus.ack0) begin
                acks++;
                bus.val0 = 5'($urandom);
                if (acks == 9) bus.req0 = 1'b0;
            end
            ef = (c < 2) ? 0 : ((c - 2) / 4 + 1);
            if (ef > RA) ef = RA;
            total_cnt++;
            if (o_fill !== 4'(ef) || o_window_full !== (ef == RA))
                $display("FAIL fill_c%0d: got fill %0d full %0d exp fill %0d full %0d",
                         c, o_fill, o_window_full, ef, (ef == RA));
            else pass_cnt++;
        end
        total_cnt++;
        if (acks != 9) $display("FAIL fill_acks: got %0d exp 9", acks);
        else pass_cnt++;
    endtask

    task automatic test_flush;
        int acks = 0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        bus.req0 = 1'b1;
        for (int i = 0; i < 40 && acks < 5; i++) begin
            step();
            if (bus.ack0) acks++;
        end
        bus.req0 = 1'b0;
        step(); step(); step();
        total_cnt++;
        if (acks != 5 || o_fill !== 4'd5)
            $display("FAIL flush_prefill: got acks %0d fill %0d exp 5 5", acks, o_fill);
        else pass_cnt++;
        bus.req0 = 1'b1; bus.val0 = 5'd22;
        step();
        total_cnt++;
        if ({bus.ack0, o_data_clk, o_fill} !== {2'b11, 4'd5})
            $display("FAIL flush_strobe: got %h exp %h", {bus.ack0, o_data_clk, o_fill}, {2'b11, 4'd5});
        else pass_cnt++;
        bus.req0 = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        total_cnt++;
        if ({o_data_clk, o_fill, o_window_full, o_value} !== {1'b0, 4'd0, 1'b0, 5'd22})
            $display("FAIL flush_clear: got %h exp %h",
                     {o_data_clk, o_fill, o_window_full, o_value}, {1'b0, 4'd0, 1'b0, 5'd22});
        else pass_cnt++;
        step();
        total_cnt++;
        if (o_fill !== 4'd0) $display("FAIL flush_not_counted: got %0d exp 0", o_fill);
        else pass_cnt++;
        step();
    endtask

    task automatic test_reset_mid;
        bus.req0 = 1'b1; bus.val0 = 5'd7;
        step();
        total_cnt++;
        if (o_data_clk !== 1'b1) $display("FAIL rstmid_strobe: got %b exp 1", o_data_clk);
        else pass_cnt++;
        bus.req0 = 1'b0; bus.req1 = 1'b1; bus.val1 = 5'd12;
        rst = 1'b1;
        step();
        total_cnt++;
        if ({o_data_clk, o_fill, bus.ack0, bus.ack1} !== 7'd0)
            $display("FAIL rstmid_drop: got %h exp 0", {o_data_clk, o_fill, bus.ack0, bus.ack1});
        else pass_cnt++;
        rst = 1'b0;
        step();
        total_cnt++;
        if ({bus.ack0, bus.ack1, o_src, o_data_clk, o_value} !== {4'b0111, 5'd12})
            $display("FAIL rstmid_regrant: got %h exp %h",
                     {bus.ack0, bus.ack1, o_src, o_data_clk, o_value}, {4'b0111, 5'd12});
        else pass_cnt++;
        bus.req1 = 1'b0;
        step(); step(); step();
    endtask

    // Timestamp model: each grant at cycle g owns strobe cycles g+1..g+S and
    // the arbiter is next free at g+S+G+1.
    task automatic test_random;
        int cyc = 0, free_at = 0, g = -100, inc_at = -1, fill = 0;
        bit void_s = 0, last = 1, grant = 0, sel = 0, exp_src = 0;
        logic [B-1:0] exp_val = '0;
        bit seen0 = 0, seen1 = 0;
        rst = 1'b1; idle_inputs();
        for (int n = 0; n < 400; n++) begin
            if (n > 0) rst = ($urandom_range(0, 59) == 0);
            if (seen0 || (bus.req0 && $urandom_range(0, 15) == 0)) bus.req0 = 1'b0;
            else if (!bus.req0 && $urandom_range(0, 2) == 0) begin bus.req0 = 1'b1; bus.val0 = 5'($urandom); end
            if (seen1 || (bus.req1 && $urandom_range(0, 15) == 0)) bus.req1 = 1'b0;
            else if (!bus.req1 && $urandom_range(0, 2) == 0) begin bus.req1 = 1'b1; bus.val1 = 5'($urandom); end
            flush = ($urandom_range(0, 19) == 0);
            grant = 0;
            if (rst) begin
                fill = 0; last = 1; free_at = cyc + 1; g = -100; inc_at = -1;
                exp_val = '0; exp_src = 0;
            end else begin
                if (flush && cyc >= g + 1 && cyc <= g + S) void_s = 1;
                if (flush) fill = 0;
                else if (cyc == inc_at && !void_s && fill < RA) fill++;
                if (cyc >= free_at && (bus.req0 || bus.req1)) begin
                    grant = 1;
                    if (bus.req0 && bus.req1) sel = RR ? !last : 1'b0;
                    else sel = !bus.req0;
                    last = sel; exp_src = sel;
                    exp_val = sel ? bus.val1 : bus.val0;
                    g = cyc; free_at = cyc + S + G + 1; inc_at = cyc + S; void_s = 0;
                end
            end
            step();
            cyc++;
            seen0 = bus.ack0; seen1 = bus.ack1;
            total_cnt++;
            if ({bus.ack0, bus.ack1, o_data_clk, o_src, o_value, o_fill, o_window_full} !==
                {grant && !sel, grant && sel, (cyc >= g + 1 && cyc <= g + S), exp_src, exp_val,
                 4'(fill), fill == RA})
                $display("FAIL random_c%0d: got %h exp %h", cyc,
                         {bus.ack0, bus.ack1, o_data_clk, o_src, o_value, o_fill, o_window_full},
                         {grant && !sel, grant && sel, (cyc >= g + 1 && cyc <= g + S), exp_src, exp_val,
                          4'(fill), fill == RA});
            else pass_cnt++;
        end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_single();
        test_contention();
        test_fill();
        test_flush();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/ra_sample_arbiter.md
RA_SAMPLE_ARBITER -- requirements
Module: ra_sample_arbiter

Interface
REQ-001 Parameter RA_SIZE, default 8: rolling-average window depth in samples.
REQ-002 Parameter BITS_PER_ELEM, default 5: sample width in bits.
REQ-003 Parameter STROBE_CYCLES, default 1, minimum 1: cycles o_data_clk is held high per sample.
REQ-004 Parameter GAP_CYCLES, default 2, minimum 1: cycles o_data_clk is held low after each strobe.
REQ-005 clk  input  1  single clock; all logic SHALL be on its rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 req0  input  1  requester 0 sample request, level.
REQ-008 val0  input  BITS_PER_ELEM  requester 0 sample value.
REQ-009 ack0  output  1  one-cycle pulse: val0 captured.
REQ-010 req1 / val1 / ack1  as REQ-007..009, requester 1.
REQ-011 flush  input  1  clear window fill tracking.
REQ-012 o_data_clk  output  1  sample strobe to the rolling-average core data-clock input.
REQ-013 o_value  output  BITS_PER_ELEM  sample to the rolling-average core value input.
REQ-014 o_src  output  1  index of the requester owning o_value.
REQ-015 o_fill  output  $clog2(RA_SIZE+1)  samples delivered since reset/flush, saturating.
REQ-016 o_window_full  output  1  high when o_fill == RA_SIZE.

Function
REQ-017 FSM states SHALL be IDLE, STROBE, GAP; all outputs SHALL be registered.
REQ-018 In IDLE with any req high at cycle N, the FSM SHALL grant exactly one requester and enter STROBE at N+1.
REQ-019 On grant, the FSM SHALL capture the granted val into o_value, set o_src, and pulse the granted ack high at N+1 for exactly one cycle.
REQ-020 o_data_clk SHALL be high for exactly STROBE_CYCLES cycles starting at N+1, then low for GAP_CYCLES cycles in GAP.
REQ-021 After GAP the FSM SHALL return to IDLE for at least one cycle; the minimum sample period is STROBE_CYCLES+GAP_CYCLES+1 cycles.
REQ-022 o_value and o_src SHALL hold stable from grant until the next grant.
REQ-023 Requests arriving in STROBE or GAP SHALL wait; req and val are sampled only in IDLE.
REQ-024 A requester SHALL hold req and val until its ack; dropping req before ack is a withdrawal with no side effect.
REQ-025 o_fill SHALL increment on the last STROBE cycle and saturate at RA_SIZE.
REQ-026 flush SHALL clear o_fill to 0 in any state, taking precedence over a same-cycle increment; an in-flight strobe SHALL complete but is not counted.
REQ-027 flush SHALL NOT affect FSM state, o_value, o_src, or the arbitration pointer.

Reset
REQ-028 While rst is high: FSM=IDLE, o_data_clk=0, ack0=ack1=0, o_value=0, o_src=0, o_fill=0, o_window_full=0, last-grant pointer=1.
REQ-029 rst mid-STROBE SHALL drop o_data_clk to 0 on the next edge; no ack SHALL be emitted during or at release of reset.
REQ-030 rst SHALL take precedence over flush and requests.

Configuration
REQ-031 Macro RA_ARB_RR_EN defined: round-robin; on contention, grant the requester not granted last; pointer updates on each grant.
REQ-032 RA_ARB_RR_EN undefined: fixed priority; req0 always wins contention; the pointer register is absent.
REQ-033 Uncontended behaviour SHALL be identical with and without the macro.

Verification (STROBE_CYCLES=1, GAP_CYCLES=2, RA_SIZE=8, BITS_PER_ELEM=5)
REQ-034 Single request: req0=1, val0=5'd17 at cycle 0 -> cycle 1: ack0=1, o_data_clk=1, o_value=17, o_src=0; cycles 2-3: o_data_clk=0; IDLE at cycle 4; o_fill=1.
REQ-035 Contention, RR_EN defined: req0 and req1 held high -> grants alternate 0,1,0,1 at a 4-cycle period; undefined -> four grants to 0, req1 starved.
REQ-036 Fill: 9 back-to-back req0 samples -> o_fill reaches 8, o_window_full rises after the 8th strobe, 9th leaves o_fill=8.
REQ-037 Flush: o_fill=5, flush asserted in the last STROBE cycle -> o_fill=0 next cycle, strobe completes, o_window_full=0.
REQ-038 Reset mid-op: rst asserted in STROBE -> next cycle o_data_clk=0, o_fill=0; after release with req1=1, first grant goes to requester 1 within 1 cycle.
